// File: rtl/handshake_watchdog_pkg.sv
// Shared definitions for the handshake watchdog.
//   wd_mode_e    : per-channel supervision mode (inactivity or stall).
//   wd_idx_width : width of a channel index for a given channel count.
package handshake_watchdog_pkg;

  typedef enum logic {
    WdIdle  = 1'b0,  // count cycles with no completed transfer
    WdStall = 1'b1   // count cycles where valid is held against low ready
  } wd_mode_e;

  // A single-channel block still carries a 1-bit index so the port never collapses.
  function automatic int wd_idx_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/handshake_watchdog_channel.sv
// One supervised handshake: cycle counter, sticky trip flag, limit compare.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              channel enable (disabled -> counter held at 0, trip holds)
//   i_mode            WdIdle / WdStall
//   i_limit           trip threshold, 0 disables tripping
//   i_valid, i_ready  monitored handshake
//   i_clear           clears counter and trip flag
//   o_tripped         sticky trip flag (registered)
//   o_count           current counter value (registered)
//
// Handshake semantics: a transfer completes on a cycle where valid and ready
// are both high (fire); valid high with ready low is a stall.
module handshake_watchdog_channel
  import handshake_watchdog_pkg::*;
#(
  parameter int CntWidth = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  wd_mode_e            i_mode,
  input  logic [CntWidth-1:0] i_limit,
  input  logic                i_valid,
  input  logic                i_ready,
  input  logic                i_clear,
  output logic                o_tripped,
  output logic [CntWidth-1:0] o_count
);

  logic [CntWidth-1:0] r_cnt;
  logic                r_tripped;

  logic                w_fire;
  logic                w_stall;
  logic                w_counting;
  logic [CntWidth:0]   w_sum;
  logic                w_limit_hit;

  assign w_fire  = i_valid & i_ready;
  assign w_stall = i_valid & ~i_ready;

  // Counting cycle: idle mode without a transfer, or stall mode with a stall.
  assign w_counting = ((i_mode == WdIdle) & ~w_fire) |
                      ((i_mode == WdStall) & w_stall);

  // One extra bit so the compare sees cnt+1 without wrapping at saturation.
  assign w_sum       = {1'b0, r_cnt} + {{CntWidth{1'b0}}, 1'b1};
  assign w_limit_hit = (i_limit != '0) && (w_sum >= {1'b0, i_limit});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_tripped <= 1'b0;
    end else if (i_clear) begin
      // Clear wins over a trip landing on the same edge.
      r_cnt     <= '0;
      r_tripped <= 1'b0;
    end else if (!i_en) begin
      r_cnt     <= '0;
    end else if (w_counting) begin
      if (!w_sum[CntWidth]) begin
        r_cnt <= w_sum[CntWidth-1:0];
      end
      if (w_limit_hit) begin
        r_tripped <= 1'b1;
      end
    end else begin
      // A fire, or stall mode with valid low, restarts the count.
      r_cnt <= '0;
    end
  end

  assign o_tripped = r_tripped;
  assign o_count   = r_cnt;

endmodule

// File: rtl/handshake_watchdog.sv
// Multi-channel valid/ready watchdog with sticky per-channel trips, an
// aggregated interrupt and a first-offender index.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   en_i            per-channel enable
//   mode_i          per-channel mode (0 inactivity, 1 stall)
//   limit_i         shared trip threshold in cycles, 0 disables trips
//   valid_i/ready_i monitored handshakes
//   clear_i         per-channel clear of trip flag and counter
//   tripped_o       sticky trip flags (registered)
//   count_o         packed counters, channel 0 in the LSBs
//   irq_o           OR of tripped_o
//   first_valid_o   a first-offender index is held
//   first_idx_o     index of the first channel to trip
//
// Handshake semantics: a transfer completes on a cycle where valid and ready
// are both high (fire); valid high with ready low is a stall.
module handshake_watchdog
  import handshake_watchdog_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 16,
  parameter int IdxWidth    = wd_idx_width(NumChannels)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumChannels-1:0]          en_i,
  input  logic [NumChannels-1:0]          mode_i,
  input  logic [CntWidth-1:0]             limit_i,
  input  logic [NumChannels-1:0]          valid_i,
  input  logic [NumChannels-1:0]          ready_i,
  input  logic [NumChannels-1:0]          clear_i,
  output logic [NumChannels-1:0]          tripped_o,
  output logic [NumChannels*CntWidth-1:0] count_o,
  output logic                            irq_o,
  output logic                            first_valid_o,
  output logic [IdxWidth-1:0]             first_idx_o
);

  logic [NumChannels-1:0] w_tripped;
  logic [IdxWidth-1:0]    w_low_idx;
  logic                   w_first_clear;
  logic                   r_first_valid;
  logic [IdxWidth-1:0]    r_first_idx;

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    handshake_watchdog_channel #(
      .CntWidth (CntWidth)
    ) u_ch (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_en      (en_i[g]),
      .i_mode    (wd_mode_e'(mode_i[g])),
      .i_limit   (limit_i),
      .i_valid   (valid_i[g]),
      .i_ready   (ready_i[g]),
      .i_clear   (clear_i[g]),
      .o_tripped (w_tripped[g]),
      .o_count   (count_o[g*CntWidth +: CntWidth])
    );
  end

  // Lowest tripped index; scanning downward lets the lowest index win.
  always_comb begin
    w_low_idx = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (w_tripped[i]) begin
        w_low_idx = IdxWidth'(i);
      end
    end
  end

  // Clear addressed at the held offender, resolved without a variable index.
  always_comb begin
    w_first_clear = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      if ((r_first_idx == IdxWidth'(i)) && clear_i[i]) begin
        w_first_clear = 1'b1;
      end
    end
  end

  // Loads from the registered trip flags, so it follows a trip by one cycle.
  // After the held offender is cleared it drops for one cycle and then picks
  // up the lowest channel still tripped; the index holds while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
    end else if (r_first_valid) begin
      if (w_first_clear) begin
        r_first_valid <= 1'b0;
      end
    end else if (|w_tripped) begin
      r_first_valid <= 1'b1;
      r_first_idx   <= w_low_idx;
    end
  end

  assign tripped_o     = w_tripped;
  assign irq_o         = |w_tripped;
  assign first_valid_o = r_first_valid;
  assign first_idx_o   = r_first_idx;

endmodule
